// File: rtl/pulse_blinker.sv
// Queued LED blinker: each trig request yields one ON_TIME-long blink followed by
// an OFF_TIME gap; requests arriving during a blink are counted up to MAX_PENDING.
module pulse_blinker #(
    parameter int ON_TIME     = 10_000_000,
    parameter int OFF_TIME    = 10_000_000,
    parameter int MAX_PENDING = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             trig,
    input  logic                             clr_ovf,
    output logic                             led,
    output logic                             busy,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending,
    output logic                             overflow
);

    localparam int TMAX = (ON_TIME > OFF_TIME) ? ON_TIME : OFF_TIME;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(MAX_PENDING + 1);

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TIME - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TIME - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state  = IDLE;
    logic [TW-1:0] timer  = '0;
    logic          led_q  = 1'b0;
    logic          busy_q = 1'b0;
    logic [PW-1:0] pend_q = '0;
    logic          ovf_q  = 1'b0;

    logic work;
    logic can_start;
    logic start;
    logic drop;

    // A blink may only begin from IDLE or on the final cycle of the OFF gap.
    assign work      = trig || (pend_q != '0);
    assign can_start = (state == IDLE) || ((state == OFF) && (timer == OFF_LAST));
    assign start     = can_start && work;
    assign drop      = trig && !start && (pend_q == PEND_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ON;
                        timer  <= '0;
                        led_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                ON: begin
                    if (timer == ON_LAST) begin
                        state <= OFF;
                        timer <= '0;
                        led_q <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                OFF: begin
                    if (timer == OFF_LAST) begin
                        timer <= '0;
                        if (start) begin
                            state <= ON;
                            led_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    timer  <= '0;
                    led_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase

            // A trig coinciding with a start is used directly and never touches the queue.
            if (start && !trig) begin
                pend_q <= pend_q - 1'b1;
            end else if (!start && trig && (pend_q != PEND_MAX)) begin
                pend_q <= pend_q + 1'b1;
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_blinker.sv
// Scoreboarded bench for pulse_blinker with ON_TIME=4, OFF_TIME=3, MAX_PENDING=2:
// directed scenarios with fixed timing checks plus a random trig/clear/reset run.
module tb_pulse_blinker;

    localparam int ON_T  = 4;
    localparam int OFF_T = 3;
    localparam int MAXP  = 2;
    localparam int PW    = $clog2(MAXP + 1);
    localparam int NMAX  = 512;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          trig    = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          led;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_blinker #(
        .ON_TIME(ON_T),
        .OFF_TIME(OFF_T),
        .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trig(trig),
        .clr_ovf(clr_ovf),
        .led(led),
        .busy(busy),
        .pending(pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int led;
        int busy;
        int pend;
        int ovf;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: phase 0=idle, 1=on, 2=off; m_left = cycles remaining in phase.
    int m_phase = 0;
    int m_left  = 0;
    int m_pend  = 0;
    int m_ovf   = 0;

    bit trig_v [0:NMAX-1];
    bit clr_v  [0:NMAX-1];
    bit rst_v  [0:NMAX-1];
    int led_log  [0:NMAX-1];
    int busy_log [0:NMAX-1];
    int pend_log [0:NMAX-1];
    int ovf_log  [0:NMAX-1];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, actual, expected);
        end
    endtask

    task automatic modelStep(input bit t, input bit c, input bit r);
        bit   work;
        bit   start;
        bit   dropped;
        exp_t e;
        if (r) begin
            m_phase = 0;
            m_left  = 0;
            m_pend  = 0;
            m_ovf   = 0;
        end else begin
            work    = t || (m_pend > 0);
            start   = work && ((m_phase == 0) || (m_phase == 2 && m_left == 1));
            dropped = 1'b0;
            if (start && !t) m_pend--;
            else if (!start && t) begin
                if (m_pend < MAXP) m_pend++;
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1;
            else if (c) m_ovf = 0;
            if (start) begin
                m_phase = 1;
                m_left  = ON_T;
            end else if (m_phase == 1) begin
                if (m_left == 1) begin
                    m_phase = 2;
                    m_left  = OFF_T;
                end else m_left--;
            end else if (m_phase == 2) begin
                if (m_left == 1) m_phase = 0;
                else m_left--;
            end
        end
        e.led  = (m_phase == 1) ? 1 : 0;
        e.busy = (m_phase != 0) ? 1 : 0;
        e.pend = m_pend;
        e.ovf  = m_ovf;
        sb.push_back(e);
    endtask

    task automatic clearVectors();
        for (int i = 0; i < NMAX; i++) begin
            trig_v[i] = 1'b0;
            clr_v[i]  = 1'b0;
            rst_v[i]  = 1'b0;
        end
        rst_v[0] = 1'b1;
    endtask

    // Called #1 after a posedge; each iteration checks the cycle just begun, then drives it.
    task automatic applyStimulus(input int ncyc);
        exp_t e;
        sb.delete();
        for (int c = 0; c < ncyc; c++) begin
            cyc         = c;
            led_log[c]  = int'(led);
            busy_log[c] = int'(busy);
            pend_log[c] = int'(pending);
            ovf_log[c]  = int'(overflow);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("led", int'(led), e.led);
                checkOutput("busy", int'(busy), e.busy);
                checkOutput("pending", int'(pending), e.pend);
                checkOutput("overflow", int'(overflow), e.ovf);
            end
            rst     = rst_v[c];
            trig    = trig_v[c];
            clr_ovf = clr_v[c];
            modelStep(trig_v[c], clr_v[c], rst_v[c]);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        trig    = 1'b0;
        clr_ovf = 1'b0;
    endtask

    initial begin
        int ones;
        #1;
        checkOutput("powerup_led", int'(led), 0);
        checkOutput("powerup_busy", int'(busy), 0);
        checkOutput("powerup_pending", int'(pending), 0);
        checkOutput("powerup_overflow", int'(overflow), 0);
        @(posedge clk);
        #1;

        $display("[TB] single blink");
        clearVectors();
        trig_v[10] = 1'b1;
        applyStimulus(40);
        checkOutput("single_led10", led_log[10], 0);
        checkOutput("single_led11", led_log[11], 1);
        checkOutput("single_led14", led_log[14], 1);
        checkOutput("single_led15", led_log[15], 0);
        checkOutput("single_busy17", busy_log[17], 1);
        checkOutput("single_busy18", busy_log[18], 0);

        $display("[TB] queued blinks");
        clearVectors();
        trig_v[10] = 1'b1;
        trig_v[12] = 1'b1;
        trig_v[13] = 1'b1;
        applyStimulus(40);
        checkOutput("queue_pend13", pend_log[13], 1);
        checkOutput("queue_pend14", pend_log[14], 2);
        checkOutput("queue_led17", led_log[17], 0);
        checkOutput("queue_led18", led_log[18], 1);
        checkOutput("queue_pend24", pend_log[24], 1);
        checkOutput("queue_led25", led_log[25], 1);
        checkOutput("queue_pend25", pend_log[25], 0);
        checkOutput("queue_busy31", busy_log[31], 1);
        checkOutput("queue_busy32", busy_log[32], 0);

        $display("[TB] overflow and clear");
        clearVectors();
        for (int i = 10; i <= 13; i++) trig_v[i] = 1'b1;
        clr_v[30] = 1'b1;
        applyStimulus(45);
        checkOutput("ovf_flag13", ovf_log[13], 0);
        checkOutput("ovf_flag14", ovf_log[14], 1);
        checkOutput("ovf_pend14", pend_log[14], 2);
        checkOutput("ovf_flag30", ovf_log[30], 1);
        checkOutput("ovf_flag31", ovf_log[31], 0);
        ones = 0;
        for (int i = 1; i < 45; i++) if (led_log[i] == 1 && led_log[i-1] == 0) ones++;
        checkOutput("ovf_blinks", ones, 3);

        $display("[TB] reset mid-blink");
        clearVectors();
        trig_v[10] = 1'b1;
        trig_v[12] = 1'b1;
        rst_v[12]  = 1'b1;
        applyStimulus(40);
        checkOutput("rst_led12", led_log[12], 1);
        checkOutput("rst_led13", led_log[13], 0);
        checkOutput("rst_busy13", busy_log[13], 0);
        ones = 0;
        for (int i = 13; i < 40; i++) ones += led_log[i];
        checkOutput("rst_no_blinks", ones, 0);

        $display("[TB] trig on last OFF cycle");
        clearVectors();
        trig_v[10] = 1'b1;
        trig_v[17] = 1'b1;
        applyStimulus(30);
        checkOutput("lastoff_led17", led_log[17], 0);
        checkOutput("lastoff_led18", led_log[18], 1);
        checkOutput("lastoff_led21", led_log[21], 1);
        checkOutput("lastoff_busy18", busy_log[18], 1);
        checkOutput("lastoff_pend18", pend_log[18], 0);

        $display("[TB] full queue with trig on last OFF cycle");
        clearVectors();
        trig_v[10] = 1'b1;
        trig_v[11] = 1'b1;
        trig_v[12] = 1'b1;
        trig_v[17] = 1'b1;
        applyStimulus(40);
        checkOutput("fullq_pend17", pend_log[17], 2);
        checkOutput("fullq_led18", led_log[18], 1);
        checkOutput("fullq_pend18", pend_log[18], 2);
        checkOutput("fullq_ovf18", ovf_log[18], 0);

        $display("[TB] random traffic");
        clearVectors();
        for (int i = 1; i < 400; i++) begin
            trig_v[i] = ($urandom_range(0, 2) == 0);
            clr_v[i]  = ($urandom_range(0, 19) == 0);
            rst_v[i]  = ($urandom_range(0, 149) == 0);
        end
        applyStimulus(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_blinker.md
PULSE_BLINKER -- requirements
Module: pulse_blinker

Interface
REQ-001 SHALL have parameter ON_TIME, default 10_000_000, LED-on duration in clk cycles per blink (>=1).
REQ-002 SHALL have parameter OFF_TIME, default 10_000_000, minimum LED-off gap in clk cycles after each blink (>=1).
REQ-003 SHALL have parameter MAX_PENDING, default 7, maximum queued blink requests (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port trig  input  1  single-cycle event request, sampled at posedge clk.
REQ-007 SHALL have port clr_ovf  input  1  clears overflow flag.
REQ-008 SHALL have port led  output  1  registered human-visible blink output.
REQ-009 SHALL have port busy  output  1  high while in ON or OFF state.
REQ-010 SHALL have port pending  output  $clog2(MAX_PENDING+1)  queued requests not yet started.
REQ-011 SHALL have port overflow  output  1  sticky flag: a request was dropped.

Function
REQ-012 SHALL implement states IDLE, ON, OFF with one internal timer of width $clog2(max(ON_TIME,OFF_TIME)+1).
REQ-013 SHALL define "work available" at an edge as trig==1 or pending>0.
REQ-014 IDLE: led=0, busy=0; on edge with work available, SHALL enter ON, timer=0.
REQ-015 ON: led=1 for exactly ON_TIME consecutive cycles, then SHALL enter OFF, timer=0.
REQ-016 OFF: led=0 for exactly OFF_TIME consecutive cycles; at final OFF cycle edge SHALL enter ON if work available, else IDLE.
REQ-017 Latency: trig high in cycle n with state IDLE SHALL give led=1 from cycle n+1.
REQ-018 Starting a blink SHALL consume trig if asserted that edge, else decrement pending by 1.
REQ-019 trig not consumed by a blink start SHALL increment pending if pending<MAX_PENDING.
REQ-020 trig not consumed while pending==MAX_PENDING SHALL be dropped and set overflow=1.
REQ-021 Simultaneous trig and blink start with pending==MAX_PENDING SHALL leave pending unchanged and overflow unchanged (trig consumed directly).
REQ-022 clr_ovf SHALL clear overflow next edge; simultaneous set condition (REQ-020) SHALL win.
REQ-023 pending SHALL never exceed MAX_PENDING nor wrap below 0.
REQ-024 busy and led SHALL be registered, glitch-free, and change only at posedge clk.
REQ-025 Back-to-back blinks SHALL always be separated by exactly OFF_TIME low cycles.

Reset
REQ-026 rst SHALL have priority over trig and clr_ovf.
REQ-027 On rst edge: state=IDLE, led=0, busy=0, pending=0, overflow=0, timer=0.
REQ-028 rst mid-ON or mid-OFF SHALL abort immediately; queued requests discarded; led=0 from next cycle.
REQ-029 Power-up register values SHALL equal reset values.

Verification (ON_TIME=4, OFF_TIME=3, MAX_PENDING=2)
REQ-030 Single trig cycle 10 -> led=1 cycles 11-14, led=0 15-17, busy=1 cycles 11-17, busy=0 cycle 18, pending=0 throughout.
REQ-031 trig cycles 10,12,13 -> pending 1 then 2; blinks led=1 cycles 11-14, 18-21, 25-28; pending returns to 0 at cycle 25; busy=0 at cycle 32.
REQ-032 trig cycles 10,11,12,13 -> pending=2, overflow=1 from cycle 14; exactly 3 blinks; clr_ovf cycle 30 -> overflow=0 cycle 31.
REQ-033 trig cycle 10, rst cycle 12 -> led=0, busy=0 from cycle 13; trig cycle 12 ignored; no further blinks.
REQ-034 trig cycle 10, second trig cycle 17 (last OFF cycle, pending=0) -> led=1 cycles 18-21 with no IDLE cycle, pending stays 0.
REQ-035 pending=2 in OFF, trig on last OFF cycle -> blink starts, pending stays 2, overflow stays 0.
